// File: rtl/cm_config_master_pkg.sv
// rtl/cm_config_master_pkg.sv - shared levels, config addresses and FSM encodings for the CM config bus
package cm_config_master_pkg;

  localparam logic ACTIVE = 1'b0;

  localparam int CM_ADDR_WIDTH = 4;
  localparam int CM_DATA_WIDTH = 16;

  localparam logic [CM_ADDR_WIDTH-1:0] ADDR_VGA_CONFIG  = 4'h0;
  localparam logic [CM_ADDR_WIDTH-1:0] ADDR_VGA_COLOR   = 4'h1;
  localparam logic [CM_ADDR_WIDTH-1:0] ADDR_VGA_QUADRAN = 4'h2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ISSUE    = 2'b01,
    ST_WAIT_ACK = 2'b10
  } cm_state_e;

  function automatic logic is_active(input logic level);
    return level == ACTIVE;
  endfunction

endpackage

// File: rtl/cm_config_master_cmd_fifo.sv
// rtl/cm_config_master_cmd_fifo.sv - command queue holding {addr, data} until the write is acked or dropped
module cm_cmd_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cm_config_master.sv
// rtl/cm_config_master.sv - CM config bus initiator: queues commands, strobes them out, retries and reports drops
module cm_config_master
  import cm_config_master_pkg::*;
#(
  parameter int C_ADDR_WIDTH = CM_ADDR_WIDTH,
  parameter int C_DATA_WIDTH = CM_DATA_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT      = 8,
  parameter int MAX_RETRY    = 2,
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [C_ADDR_WIDTH-1:0] Cmd_Addr,
  input  logic [C_DATA_WIDTH-1:0] Cmd_Data,
  input  logic                    Cmd_Valid,
  output logic                    Cmd_Rdy,
  input  logic                    C_Rdy,
  output logic [C_ADDR_WIDTH-1:0] C_Addr,
  output logic [C_DATA_WIDTH-1:0] C_Data,
  output logic                    C_Valid,
  output logic                    Busy,
  output logic                    Err,
  output logic [C_ADDR_WIDTH-1:0] Err_Addr,
  output logic [ERRCNT_WIDTH-1:0] Err_Cnt,
  input  logic                    Err_Clr
);

  localparam int FW = C_ADDR_WIDTH + C_DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  cm_state_e state, state_nxt;

  logic [FW-1:0]           fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic                    drop;

  logic [C_ADDR_WIDTH-1:0] c_addr_q, c_addr_nxt;
  logic [C_DATA_WIDTH-1:0] c_data_q, c_data_nxt;
  logic                    c_valid_q, c_valid_nxt;
  logic [TW-1:0]           tcnt, tcnt_nxt;
  logic [RW-1:0]           rcnt, rcnt_nxt;
  logic                    err_q, err_nxt;
  logic [C_ADDR_WIDTH-1:0] err_addr_q, err_addr_nxt;
  logic [ERRCNT_WIDTH-1:0] err_cnt_q, err_cnt_nxt;

  cm_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (Cmd_Valid),
    .wdata ({Cmd_Addr, Cmd_Data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The head stays queued while in flight, so a retry or reset never loses ordering.
  always_comb begin
    state_nxt   = state;
    c_addr_nxt  = c_addr_q;
    c_data_nxt  = c_data_q;
    c_valid_nxt = ~ACTIVE;
    tcnt_nxt    = tcnt;
    rcnt_nxt    = rcnt;
    fifo_pop    = 1'b0;
    drop        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          {c_addr_nxt, c_data_nxt} = fifo_head;
          c_valid_nxt = ACTIVE;
          rcnt_nxt    = '0;
          state_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tcnt_nxt  = '0;
        state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (is_active(C_Rdy)) begin
          fifo_pop  = 1'b1;
          rcnt_nxt  = '0;
          state_nxt = ST_IDLE;
        end else if (tcnt == T_LAST) begin
          if (rcnt < R_MAX) begin
            rcnt_nxt    = rcnt + 1'b1;
            c_valid_nxt = ACTIVE;
            state_nxt   = ST_ISSUE;
          end else begin
            drop      = 1'b1;
            fifo_pop  = 1'b1;
            rcnt_nxt  = '0;
            state_nxt = ST_IDLE;
          end
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A drop coinciding with a clear still leaves a record of that drop.
  always_comb begin
    err_nxt      = err_q;
    err_addr_nxt = err_addr_q;
    err_cnt_nxt  = err_cnt_q;
    if (drop) begin
      err_nxt      = 1'b1;
      err_addr_nxt = c_addr_q;
      if (Err_Clr)         err_cnt_nxt = ERRCNT_WIDTH'(1);
      else if (!(&err_cnt_q)) err_cnt_nxt = err_cnt_q + 1'b1;
    end else if (Err_Clr) begin
      err_nxt      = 1'b0;
      err_addr_nxt = '0;
      err_cnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      c_addr_q   <= '0;
      c_data_q   <= '0;
      c_valid_q  <= ~ACTIVE;
      tcnt       <= '0;
      rcnt       <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state      <= state_nxt;
      c_addr_q   <= c_addr_nxt;
      c_data_q   <= c_data_nxt;
      c_valid_q  <= c_valid_nxt;
      tcnt       <= tcnt_nxt;
      rcnt       <= rcnt_nxt;
      err_q      <= err_nxt;
      err_addr_q <= err_addr_nxt;
      err_cnt_q  <= err_cnt_nxt;
    end
  end

  assign C_Addr   = c_addr_q;
  assign C_Data   = c_data_q;
  assign C_Valid  = c_valid_q;
  assign Cmd_Rdy  = ~fifo_full;
  assign Busy     = ~fifo_empty | (state != ST_IDLE);
  assign Err      = err_q;
  assign Err_Addr = err_addr_q;
  assign Err_Cnt  = err_cnt_q;

endmodule

// File: tb/tb_cm_config_master.sv
// tb/tb_cm_config_master.sv - randomized bench for cm_config_master against a transaction-level schedule model
module tb_cm_config_master;
  import cm_config_master_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int TO    = 8;
  localparam int MAXR  = 2;
  localparam int ECW   = 3;
  localparam int EMAX  = (1 << ECW) - 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [AW-1:0]  Cmd_Addr;
  logic [DW-1:0]  Cmd_Data;
  logic           Cmd_Valid;
  logic           Cmd_Rdy;
  logic           C_Rdy;
  logic [AW-1:0]  C_Addr;
  logic [DW-1:0]  C_Data;
  logic           C_Valid;
  logic           Busy;
  logic           Err;
  logic [AW-1:0]  Err_Addr;
  logic [ECW-1:0] Err_Cnt;
  logic           Err_Clr;

  always #5 clk = ~clk;

  cm_config_master #(
    .C_ADDR_WIDTH (AW),
    .C_DATA_WIDTH (DW),
    .FIFO_DEPTH   (DEPTH),
    .TIMEOUT      (TO),
    .MAX_RETRY    (MAXR),
    .ERRCNT_WIDTH (ECW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Cmd_Addr  (Cmd_Addr),
    .Cmd_Data  (Cmd_Data),
    .Cmd_Valid (Cmd_Valid),
    .Cmd_Rdy   (Cmd_Rdy),
    .C_Rdy     (C_Rdy),
    .C_Addr    (C_Addr),
    .C_Data    (C_Data),
    .C_Valid   (C_Valid),
    .Busy      (Busy),
    .Err       (Err),
    .Err_Addr  (Err_Addr),
    .Err_Cnt   (Err_Cnt),
    .Err_Clr   (Err_Clr)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model: queued commands, cycle of the latest strobe of the head, attempt count, error status.
  cmd_t          m_q[$];
  cmd_t          m_bus;
  int            m_last;
  int            m_att;
  logic          m_err;
  logic [AW-1:0] m_err_addr;
  int            m_err_cnt;

  cmd_t          pend[$];
  int            push_prob, ack_min, ack_max, noise, clr_prob;
  bit            clr_on_drop;
  int            ack_at, r_att;
  bit            r_acked;
  cmd_t          r_last;
  int            n_strobes;
  bit            saw_full;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_bus      = '0;
    m_last     = -1;
    m_att      = 0;
    m_err      = 1'b0;
    m_err_addr = '0;
    m_err_cnt  = 0;
    ack_at     = -1;
    r_att      = 0;
    r_acked    = 1'b1;
    r_last     = '0;
  endtask

  // Advance the model over the clock edge that closes cycle cyc.
  task automatic model_adv(input bit ack, input bit push, input bit clr, input cmd_t pc, output bit acc);
    int sz = m_q.size();
    bit was_idle = (m_last < 0);
    bit dropped = 1'b0;
    if (!was_idle && cyc > m_last) begin
      if (ack) begin
        void'(m_q.pop_front());
        m_last = -1;
      end else if (cyc == m_last + TO) begin
        if (m_att < MAXR) begin
          m_att++;
          m_last = cyc + 1;
        end else begin
          dropped    = 1'b1;
          m_err      = 1'b1;
          m_err_addr = m_q[0].addr;
          m_err_cnt  = clr ? 1 : ((m_err_cnt < EMAX) ? m_err_cnt + 1 : EMAX);
          void'(m_q.pop_front());
          m_last = -1;
        end
      end
    end
    if (clr && !dropped) begin
      m_err      = 1'b0;
      m_err_addr = '0;
      m_err_cnt  = 0;
    end
    acc = push && (sz < DEPTH);
    if (acc) m_q.push_back(pc);
    if (was_idle && sz > 0) begin
      m_bus  = m_q[0];
      m_last = cyc + 1;
      m_att  = 0;
    end
  endtask

  task automatic step();
    bit   strobe, acc, drop_now;
    cmd_t pc;
    @(negedge clk);
    cyc++;
    strobe = (m_last == cyc);
    check("c_valid",  32'(C_Valid),  strobe ? 32'd0 : 32'd1);
    check("c_addr",   32'(C_Addr),   32'(m_bus.addr));
    check("c_data",   32'(C_Data),   32'(m_bus.data));
    check("cmd_rdy",  32'(Cmd_Rdy),  32'(m_q.size() < DEPTH));
    check("busy",     32'(Busy),     32'(m_q.size() > 0));
    check("err",      32'(Err),      32'(m_err));
    check("err_addr", 32'(Err_Addr), 32'(m_err_addr));
    check("err_cnt",  32'(Err_Cnt),  32'(m_err_cnt));
    if (C_Valid == 1'b0) n_strobes++;
    if (Cmd_Rdy == 1'b0) saw_full = 1'b1;

    // Responder: address 0xF is never acked; data bit 15 means ack only from the 2nd attempt.
    if (C_Valid == 1'b0) begin
      r_att  = ({C_Addr, C_Data} == r_last && !r_acked) ? r_att + 1 : 0;
      r_last = {C_Addr, C_Data};
      if (C_Addr == 4'hF || (C_Data[15] && r_att == 0)) begin
        ack_at  = -1;
        r_acked = 1'b0;
      end else begin
        ack_at  = cyc + $urandom_range(ack_min, ack_max);
        r_acked = 1'b1;
      end
    end
    if (cyc == ack_at)
      C_Rdy = 1'b0;
    else if ((strobe || m_last < 0) && $urandom_range(0, 99) < noise)
      C_Rdy = 1'b0;
    else
      C_Rdy = 1'b1;

    pc.addr   = 4'($urandom);
    pc.data   = 16'($urandom);
    Cmd_Valid = 1'b0;
    if (pend.size() > 0 && $urandom_range(0, 99) < push_prob) begin
      Cmd_Valid = 1'b1;
      pc = pend[0];
    end
    Cmd_Addr = pc.addr;
    Cmd_Data = pc.data;

    drop_now = (m_last >= 0 && cyc == m_last + TO && m_att == MAXR && C_Rdy == 1'b1);
    Err_Clr  = clr_on_drop ? drop_now : ($urandom_range(0, 99) < clr_prob);
    model_adv(!C_Rdy, Cmd_Valid, Err_Clr, pc, acc);
    if (acc) void'(pend.pop_front());
  endtask

  task automatic run_until_idle();
    int k = 0;
    int budget = 40 * (pend.size() + m_q.size()) + 60;
    while ((pend.size() > 0 || m_q.size() > 0) && k < budget && n_errors < 200) begin
      step();
      k++;
    end
    check("drain_in_budget", 32'(k < budget), 32'd1);
    repeat (3) step();
  endtask

  task automatic do_reset(input int cycles);
    rst_n     = 1'b0;
    Cmd_Valid = 1'b0;
    C_Rdy     = 1'b1;
    Err_Clr   = 1'b0;
    #1;
    check("rst_c_valid",  32'(C_Valid),  32'd1);
    check("rst_c_addr",   32'(C_Addr),   32'd0);
    check("rst_c_data",   32'(C_Data),   32'd0);
    check("rst_cmd_rdy",  32'(Cmd_Rdy),  32'd1);
    check("rst_busy",     32'(Busy),     32'd0);
    check("rst_err",      32'(Err),      32'd0);
    check("rst_err_addr", 32'(Err_Addr), 32'd0);
    check("rst_err_cnt",  32'(Err_Cnt),  32'd0);
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0, k;
    rst_n = 1'b1; Cmd_Valid = 1'b0; Cmd_Addr = '0; Cmd_Data = '0; C_Rdy = 1'b1; Err_Clr = 1'b0;
    push_prob = 100; ack_min = 1; ack_max = 1; noise = 0; clr_prob = 0; clr_on_drop = 1'b0;
    n_strobes = 0; saw_full = 1'b0;
    model_reset();
    #2;
    do_reset(3);
    repeat (3) step();

    // Single write, immediate ack
    s0 = n_strobes;
    pend.push_back('{ADDR_VGA_COLOR, 16'h4123});
    run_until_idle();
    check("t1_strobes", 32'(n_strobes - s0), 32'd1);
    check("t1_err", 32'(Err), 32'd0);

    // Queue fills behind a slow head; excess push waits while full
    s0 = n_strobes; saw_full = 1'b0;
    pend.push_back('{ADDR_VGA_CONFIG, 16'h8001});
    pend.push_back('{ADDR_VGA_COLOR, 16'h0011});
    pend.push_back('{ADDR_VGA_QUADRAN, 16'h0022});
    pend.push_back('{4'h3, 16'h0033});
    pend.push_back('{4'h4, 16'h0044});
    run_until_idle();
    check("t2_full_seen", 32'(saw_full), 32'd1);
    check("t2_strobes", 32'(n_strobes - s0), 32'd6);

    // Never-acked address is dropped after 1 + MAX_RETRY strobes, next command proceeds
    s0 = n_strobes;
    pend.push_back('{4'hF, 16'h1234});
    pend.push_back('{ADDR_VGA_QUADRAN, 16'h0555});
    run_until_idle();
    check("t3_strobes", 32'(n_strobes - s0), 32'd4);
    check("t3_err", 32'(Err), 32'd1);
    check("t3_err_addr", 32'(Err_Addr), 32'hF);
    check("t3_err_cnt", 32'(Err_Cnt), 32'd1);

    // Ack on 2nd attempt
    s0 = n_strobes;
    pend.push_back('{ADDR_VGA_QUADRAN, 16'h8ABC});
    run_until_idle();
    check("t4_strobes", 32'(n_strobes - s0), 32'd2);
    check("t4_err_cnt", 32'(Err_Cnt), 32'd1);

    // Reset while waiting for an ack with two more queued
    pend.push_back('{ADDR_VGA_COLOR, 16'h8AAA});
    pend.push_back('{4'h5, 16'h0BBB});
    pend.push_back('{4'h6, 16'h0CCC});
    k = 0;
    while (!(m_last >= 0 && cyc > m_last && m_q.size() == 3 && pend.size() == 0) && k < 100) begin
      step();
      k++;
    end
    check("t5_reach_wait", 32'(k < 100), 32'd1);
    do_reset(2);
    pend.delete();
    s0 = n_strobes;
    repeat (12) step();
    check("t5_no_strobe", 32'(n_strobes - s0), 32'd0);
    check("t5_busy", 32'(Busy), 32'd0);

    // Clear coinciding with a drop, then a standalone clear
    for (int i = 0; i < 5; i++) pend.push_back('{4'hF, 16'(i)});
    run_until_idle();
    check("t6_err_cnt5", 32'(Err_Cnt), 32'd5);
    clr_on_drop = 1'b1;
    pend.push_back('{4'hF, 16'h7777});
    run_until_idle();
    clr_on_drop = 1'b0;
    check("t6_err_on_drop", 32'(Err), 32'd1);
    check("t6_cnt_on_drop", 32'(Err_Cnt), 32'd1);
    check("t6_addr_on_drop", 32'(Err_Addr), 32'hF);
    clr_prob = 100;
    step();
    clr_prob = 0;
    step();
    check("t6_err_cleared", 32'(Err), 32'd0);
    check("t6_cnt_cleared", 32'(Err_Cnt), 32'd0);

    // Saturation of the drop counter
    for (int i = 0; i < EMAX + 2; i++) pend.push_back('{4'hF, 16'(i + 100)});
    run_until_idle();
    check("sat_err_cnt", 32'(Err_Cnt), 32'(EMAX));

    // Randomized traffic
    push_prob = 60; ack_min = 1; ack_max = TO; noise = 20; clr_prob = 2;
    for (int i = 0; i < 150; i++) begin
      cmd_t c;
      c.addr = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      c.data = 16'($urandom);
      c.data[15] = ($urandom_range(0, 3) == 0);
      pend.push_back(c);
    end
    run_until_idle();
    clr_prob = 0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cm_config_master.md
Name: cm_config_master

Overview:
- Initiator side of the CM configuration bus: queues configuration commands (VGA config, colour, quadrant writes) and issues them one at a time on C_Addr/C_Data/C_Valid.
- Confirms each write through the responder's C_Rdy acknowledge pulse.
- Retries writes that are not acknowledged, and reports permanently failed writes through sticky error status.
- Sits between the command source (UART/button decoder) and the CM assign-data responder.

Parameters:
- C_ADDR_WIDTH, 4, config bus address width.
- C_DATA_WIDTH, 16, config bus data width.
- FIFO_DEPTH, 4, command queue entries (power of 2, ≥2).
- TIMEOUT, 8, acknowledge window in cycles (≥2).
- MAX_RETRY, 2, re-issues after the first attempt before a command is dropped.
- ERRCNT_WIDTH, 8, dropped-command counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- Cmd_Addr  in  C_ADDR_WIDTH  command address.
- Cmd_Data  in  C_DATA_WIDTH  command data.
- Cmd_Valid  in  1  active-high push request.
- Cmd_Rdy  out  1  queue not full; a push happens only when Cmd_Valid & Cmd_Rdy.
- C_Rdy  in  1  responder acknowledge, active-low pulse.
- C_Addr  out  C_ADDR_WIDTH  bus address.
- C_Data  out  C_DATA_WIDTH  bus data.
- C_Valid  out  1  bus strobe, active-low (ACTIVE = 0).
- Busy  out  1  queue non-empty or FSM not in IDLE.
- Err  out  1  sticky: at least one command dropped.
- Err_Addr  out  C_ADDR_WIDTH  address of the last dropped command.
- Err_Cnt  out  ERRCNT_WIDTH  dropped commands, saturating.
- Err_Clr  in  1  synchronous clear of Err, Err_Addr and Err_Cnt.

Behaviour:

Reset values:
- C_Valid = 1.
- C_Addr = 0, C_Data = 0.
- Cmd_Rdy = 1.
- Busy = 0.
- Err = 0, Err_Addr = 0, Err_Cnt = 0.
- FIFO empty; FSM in IDLE; retry and timeout counters = 0.
- Reset asserted mid-operation flushes the queue and abandons any in-flight write. No C_Valid strobe follows reset release until a new command is pushed.

Output registration:
- All bus outputs are registered.
- C_Addr and C_Data hold their last issued values while idle.

FSM states: IDLE, ISSUE, WAIT_ACK.
- IDLE: if the FIFO is non-empty, load the head into C_Addr/C_Data, drive C_Valid = 0 next cycle, and go to ISSUE. The retry counter is 0 for a newly loaded command.
- ISSUE: C_Valid is low for exactly one cycle. Then drive C_Valid = 1, clear the timeout counter, and go to WAIT_ACK.
- WAIT_ACK: the acknowledge window starts in the cycle after the C_Valid low cycle.
  - C_Rdy == 0 seen → pop the head, return to IDLE, clear the retry counter.
  - C_Rdy still high after TIMEOUT cycles, retry counter < MAX_RETRY → increment the retry counter, re-issue the same command (back to ISSUE, C_Valid low next cycle).
  - Timeout with retry counter == MAX_RETRY → drop: pop the head, set Err, set Err_Addr = C_Addr, increment Err_Cnt (saturating), return to IDLE.

Timing:
- Minimum latency: push at edge E0 → C_Valid low during E1–E2 → C_Rdy low during E2–E3 → pop at E3.
- Back-to-back throughput: one command per 3 cycles.

Handshake rules:
- C_Valid is never held low for more than one cycle. This prevents duplicate writes in the responder.
- A C_Rdy low seen in IDLE or ISSUE is ignored (stale).

Queue boundary conditions:
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- When full, Cmd_Rdy = 0; a push attempt is ignored and the queue contents are unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Error-status boundary conditions:
- Err_Clr in the same cycle as a drop: the drop wins (Err = 1, Err_Cnt = 1, Err_Addr = dropped address).
- Err_Cnt holds at all-ones.

Decomposition:
- Shared package/include (with the existing CM_Addr/CM_Width parameter files): ACTIVE level; ADDR_VGA_CONFIG, ADDR_VGA_COLOR, ADDR_VGA_QUADRAN; FSM state encodings (2-bit).
- Sub-module cm_cmd_fifo: synchronous FIFO of width C_ADDR_WIDTH+C_DATA_WIDTH with push, pop, full, empty and a head output.

Test Plan:
1. Push {ADDR_VGA_COLOR, 0x4123}; responder model pulses C_Rdy low 1 cycle after the strobe → C_Valid low for exactly 1 cycle with C_Data = 0x4123, pop at E3, Busy falls, Err = 0.
2. Push 4 commands back-to-back with FIFO_DEPTH = 4, responder acking each → Cmd_Rdy low after the 4th push; a 5th push is ignored; 4 strobes issued in order, 3 cycles apart.
3. Responder never acks address 0xF → 3 strobes (1 + MAX_RETRY), each spaced TIMEOUT+1 cycles; then Err = 1, Err_Addr = 0xF, Err_Cnt = 1, and the next queued command is issued.
4. Responder acks only the 2nd attempt → exactly 2 strobes with identical addr/data, no error, command popped.
5. Assert rst_n low during WAIT_ACK with 2 commands queued → all outputs at reset values, no strobe after release, Busy = 0.
6. Assert Err_Clr in the same cycle as a drop, with Err_Cnt = 5 → Err = 1, Err_Cnt = 1; Err_Clr on a later cycle → Err = 0, Err_Cnt = 0.
